aes_decrypt_iter: RTL and testbench



---
 rtl/aes_decrypt_iter.sv | 218 +++++++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: the key is expanded forward once to round key 10, then each block
// takes ten clocks, one inverse round per clock, with round keys 9..0 rebuilt by the reverse schedule.

module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // Entry 0 sits in the top byte, so entry n starts at bit 8*(255-n) = 8*~n.
  assign o_byte = SBOX[{~i_byte, 3'b000} +: 8];
endmodule

module aes_inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  assign o_byte = INV_SBOX[{~i_byte, 3'b000} +: 8];
endmodule

module aes_decrypt_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_key_valid,
  input  logic [127:0] i_key,
  output logic         o_key_ready,
  input  logic         i_in_valid,
  input  logic [127:0] i_ciphertext,
  output logic         o_in_ready,
  output logic         o_out_valid,
  output logic [127:0] o_plaintext,
  input  logic         i_out_ready,
  output logic [2:0]   o_state
);
  // Handshakes: a word moves on the rising edge where valid and ready are both high; data is
  // sampled only on that edge, and a key offered in READY takes priority over a ciphertext.
  typedef enum logic [2:0] {
    S_NOKEY  = 3'd0,
    S_KEYEXP = 3'd1,
    S_READY  = 3'd2,
    S_DEC    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t       r_state, w_state_next;
  logic [127:0] r_rk, r_k10, r_st, r_wk, r_pt;
  logic [7:0]   r_rcon;
  logic [3:0]   r_cnt, r_round;
  logic         r_key_loaded;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] b [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      b[i]  = a[31-8*i -: 8];
      m2[i] = xt(b[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
      m9[i] = m8[i] ^ b[i];
      mb[i] = m8[i] ^ m2[i] ^ b[i];
      md[i] = m8[i] ^ m4[i] ^ b[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3], m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3], mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[32*(3-c) +: 32] = inv_mix_col(s[32*(3-c) +: 32]);
    return o;
  endfunction

  // Byte n of the state is row n%4, column n/4; row r is rotated right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c-r)&3)+r)) +: 8];
    return o;
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0]  w_p0, w_p1, w_p2, w_p3, w_n0, w_n1, w_n2, w_n3, w_sub_in, w_sub_out;
  logic [127:0] w_rk_next, w_prev, w_isr, w_isb, w_ark, w_imc;
  logic         w_key_acc, w_blk_acc;

  // The SubWord lookup is shared: KEYEXP and DEC never overlap.
  assign w_p3     = r_wk[31:0] ^ r_wk[63:32];
  assign w_p2     = r_wk[63:32] ^ r_wk[95:64];
  assign w_p1     = r_wk[95:64] ^ r_wk[127:96];
  assign w_sub_in = (r_state == S_DEC) ? {w_p3[23:0], w_p3[31:24]} : {r_rk[23:0], r_rk[31:24]};

  genvar g;
  for (g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (.i_byte(w_sub_in[8*g +: 8]), .o_byte(w_sub_out[8*g +: 8]));
  end

  assign w_n0      = r_rk[127:96] ^ w_sub_out ^ {r_rcon, 24'h0};
  assign w_n1      = r_rk[95:64] ^ w_n0;
  assign w_n2      = r_rk[63:32] ^ w_n1;
  assign w_n3      = r_rk[31:0] ^ w_n2;
  assign w_rk_next = {w_n0, w_n1, w_n2, w_n3};

  assign w_p0   = r_wk[127:96] ^ w_sub_out ^ {rcon_of(r_round), 24'h0};
  assign w_prev = {w_p0, w_p1, w_p2, w_p3};
  assign w_isr  = inv_shift_rows(r_st);

  for (g = 0; g < 16; g++) begin : g_isb
    aes_inv_sbox u_isbox (.i_byte(w_isr[8*g +: 8]), .o_byte(w_isb[8*g +: 8]));
  end

  assign w_ark = w_isb ^ w_prev;
  assign w_imc = inv_mix_cols(w_ark);

  assign o_key_ready = (r_state == S_NOKEY) || (r_state == S_READY);
  assign o_in_ready  = (r_state == S_READY) && !i_key_valid && r_key_loaded;
  assign o_out_valid = (r_state == S_DONE);
  assign o_plaintext = r_pt;
  assign o_state     = r_state;
  assign w_key_acc   = i_key_valid && o_key_ready;
  assign w_blk_acc   = i_in_valid && o_in_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_NOKEY:  if (w_key_acc) w_state_next = S_KEYEXP;
      S_KEYEXP: if (r_cnt == 4'd10) w_state_next = S_READY;
      S_READY: begin
        if (w_key_acc)      w_state_next = S_KEYEXP;
        else if (w_blk_acc) w_state_next = S_DEC;
      end
      S_DEC:    if (r_round == 4'd1) w_state_next = S_DONE;
      S_DONE:   if (i_out_ready) w_state_next = S_READY;
      default:  w_state_next = S_NOKEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_NOKEY;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk <= '0; r_k10 <= '0; r_st <= '0; r_wk <= '0; r_pt <= '0;
      r_rcon <= '0; r_cnt <= '0; r_round <= '0; r_key_loaded <= 1'b0;
    end else begin
      if (w_key_acc) begin
        r_rk         <= i_key;
        r_rcon       <= 8'h01;
        r_cnt        <= 4'd1;
        r_key_loaded <= 1'b0;
      end else if (r_state == S_KEYEXP) begin
        r_rk   <= w_rk_next;
        r_rcon <= xt(r_rcon);
        r_cnt  <= r_cnt + 4'd1;
        if (r_cnt == 4'd10) begin
          r_k10        <= w_rk_next;
          r_key_loaded <= 1'b1;
        end
      end
      if (w_blk_acc) begin
        r_st    <= i_ciphertext ^ r_k10;
        r_wk    <= r_k10;
        r_round <= 4'd10;
      end else if (r_state == S_DEC) begin
        r_wk    <= w_prev;
        r_round <= r_round - 4'd1;
        if (r_round == 4'd1) r_pt <= w_ark;
        else                 r_st <= w_imc;
      end
    end
  end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter using FIPS-197 known-answer vectors, backpressure,
// key/ciphertext collision and mid-round reset.

module tb_aes_decrypt_iter;
  logic         clk, rst_n;
  logic         key_valid, key_ready, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] key, ciphertext, plaintext;
  logic [2:0]   state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_decrypt_iter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_key_valid  (key_valid),
    .i_key        (key),
    .o_key_ready  (key_ready),
    .i_in_valid   (in_valid),
    .i_ciphertext (ciphertext),
    .o_in_ready   (in_ready),
    .o_out_valid  (out_valid),
    .o_plaintext  (plaintext),
    .i_out_ready  (out_ready),
    .o_state      (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drivers
  task automatic load_key(input logic [127:0] k);
    int n;
    check("key_rdy", key_ready, 1);
    key_valid = 1'b1;
    key = k;
    tick();
    key_valid = 1'b0;
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    check("key_lat", n, 10);
  endtask

  task automatic decrypt(input logic [127:0] ct, input logic [127:0] exp);
    int n;
    exp_q.push_back(exp);
    check("in_rdy", in_ready, 1);
    in_valid = 1'b1;
    ciphertext = ct;
    tick();
    in_valid = 1'b0;
    ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check("dec_lat", n, 10);
    check("pt", plaintext, exp_q.pop_front());
    if (out_ready) begin
      tick();
      check("post_ov", out_valid, 0);
      check("post_in_rdy", in_ready, 1);
    end
  endtask

  initial begin
    int  n;
    logic saw_ov;
    rst_n = 1'b0; key_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    key = '0; ciphertext = '0;
    repeat (3) tick();
    check("rst_key_rdy", key_ready, 1);
    check("rst_in_rdy", in_ready, 0);
    check("rst_ov", out_valid, 0);
    check("rst_pt", plaintext, 0);
    check("rst_state", state, 0);
    rst_n = 1'b1;
    tick();

    // C.1 vector, with the consumer stalled for 20 cycles
    load_key(C1_KEY);
    out_ready = 1'b0;
    decrypt(C1_CT, C1_PT);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_ov", out_valid, 1);
      check("bp_pt", plaintext, C1_PT);
      check("bp_in_rdy", in_ready, 0);
      check("bp_key_rdy", key_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("rel_ov", out_valid, 0);
    check("rel_in_rdy", in_ready, 1);
    check("rel_state", state, 2);
    check("rel_pt_hold", plaintext, C1_PT);

    // Appendix B vector, twice back to back on the same key
    load_key(B_KEY);
    decrypt(B_CT, B_PT);
    decrypt(B_CT, B_PT);

    // Key and ciphertext offered together: the key wins
    key_valid = 1'b1; key = '0;
    in_valid = 1'b1; ciphertext = B_CT;
    #1;
    check("coll_in_rdy", in_ready, 0);
    check("coll_key_rdy", key_ready, 1);
    tick();
    key_valid = 1'b0; in_valid = 1'b0;
    check("coll_state", state, 1);
    n = 0;
    saw_ov = 1'b0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
      if (out_valid) saw_ov = 1'b1;
    end
    check("coll_key_lat", n, 10);
    check("coll_no_out", saw_ov, 0);
    decrypt(Z_CT, 128'h0);

    // Reset in the middle of decryption
    in_valid = 1'b1; ciphertext = B_CT;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("mid_state", state, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mr_ov", out_valid, 0);
    check("mr_in_rdy", in_ready, 0);
    check("mr_key_rdy", key_ready, 1);
    check("mr_state", state, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mr_in_rdy2", in_ready, 0);
    load_key(C1_KEY);
    decrypt(C1_CT, C1_PT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
